atan_vectoring: RTL and testbench
=================================

# atan_vectoring

Iterative vectoring-mode CORDIC: accepts an IEEE-754 single-precision pair (y, x) and returns the angle atan(y/x) as IEEE-754 single precision.
- Inverse of the rotation-mode cosine pipeline: that block maps angle→coordinate; this one maps coordinate→angle.
- Shares the same Q2.24 atan(2^-i) constant table and float unpack/pack conventions.
- Uses one shared micro-rotation stage for ITERATIONS cycles behind a valid/ready handshake, trading throughput for area.

## Interface
- WIDTH, 24: fractional bits of internal fixed point. x/y/z datapath is WIDTH+3 bits signed, with 2 integer bits plus 1 guard bit.
- ITERATIONS, 24: micro-rotations per operation, 1..WIDTH+1.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  one clock; reset is synchronous and active-high.
- clk_en  in  1  global enable; low freezes all state and outputs.
- in_valid  in  1  y_in/x_in valid.
- in_ready  out  1  block can accept an operand pair.
- y_in  in  32  IEEE-754 single; |y| ≤ 1.0.
- x_in  in  32  IEEE-754 single; |x| ≤ 1.0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  IEEE-754 single angle in radians.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - in_ready = (state==IDLE) && !reset.
  - Accept when in_valid && in_ready; register raw y_in/x_in; go to LOAD.
- LOAD:
  - Unpack both operands to Q2.24 and sign-extend to WIDTH+3 bits.
  - Set z=0 and iteration counter i=0.
  - Apply quadrant pre-rotation (see Configuration).
  - Go to ITER.
- ITER, one micro-rotation per enabled cycle, shifts arithmetic:
  - y≥0: x←x+(y>>>i), y←y−(x>>>i), z←z+atan_i.
  - y<0: x←x−(y>>>i), y←y+(x>>>i), z←z−atan_i.
  - Both use the old x/y. y==0 takes the y≥0 branch.
  - Increment i. After the rotation with i==ITERATIONS−1, pack z into result and go to DONE.
- DONE:
  - out_valid=1; result held stable.
  - On out_ready, go to IDLE the same edge, with in_ready high the next cycle.
- Packing:
  - Normalize |z|, sign from z, mantissa truncated.
  - z==0 → 0x00000000. No NaN/Inf/denormal generation.
- Inputs:
  - Operand denormals are treated as zero.
  - x==0 && y==0 yields an unspecified finite value, but the FSM still completes normally.
- Accuracy: |result − atan2(y,x)| ≤ 4e-6 rad across the legal input range.

## Timing
- Reset values: state=IDLE, out_valid=0, result=0x00000000, internal x/y/z/i=0. in_ready=0 while reset is high.
- Reset mid-operation (LOAD/ITER/DONE) aborts the operation; no out_valid is produced for it.
- Latency: handshake at edge T → LOAD at T+1 → ITER T+2..T+1+ITERATIONS → out_valid high from cycle T+2+ITERATIONS (26 cycles at default).
- Throughput: one operation per ITERATIONS+3 cycles with out_ready held high.
- in_ready is low throughout LOAD, ITER and DONE. in_valid in those states is ignored, not queued.
- Back-pressure: out_ready low holds DONE, out_valid and result indefinitely.
- clk_en low: no state, counter, datapath or output register changes. A handshake is ignored that cycle, because in_ready is masked by clk_en.
- reset has priority over clk_en.

## Configuration
- ATAN_QUADRANT_EN defined: full atan2, result in (−π, π].
  - In LOAD, if x<0 and y≥0: (x,y)←(y,−x), z←+π/2.
  - If x<0 and y<0: (x,y)←(−y,x), z←−π/2.
  - The z range needs the guard bit.
- ATAN_QUADRANT_EN undefined:
  - No pre-rotation. The x sign bit is cleared at unpack, so the block computes atan(y/|x|).
  - Result in [−π/2, π/2].
  - The +π/2 constant and pre-rotation muxes are not synthesized.

## Test plan
- Reset, then y=0x3F800000, x=0x3F800000 → out_valid exactly 26 cycles after the handshake; result within 4e-6 of 0x3F490FDB (π/4).
- y=0x3F000000 (0.5), x=0x3F800000 → result ≈ 0x3EED6338 (0.4636476).
- y=0xBF800000, x=0x3F800000 → result ≈ 0xBF490FDB (−π/4).
- y=0x3F800000, x=0xBF800000:
  - With ATAN_QUADRANT_EN → ≈ 0x4016CBE4 (3π/4).
  - Without → ≈ 0x3F490FDB.
- Back-pressure: out_ready low for 10 cycles after out_valid → result and out_valid stable, in_ready=0. Extra in_valid pulses are dropped. Release → in_ready=1 the next cycle.
- Control: reset pulsed at ITER cycle 5 → no out_valid; next operation correct. Then clk_en low for 7 cycles mid-ITER → latency becomes 33 cycles with an identical result.

Source files
------------

// File: rtl/atan_vectoring_if.sv
// Operand/result handshake bundle for the vectoring CORDIC.
// master drives operands and out_ready; slave is the CORDIC.
interface atan_vectoring_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y_in;
    logic [31:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    modport master (
        output in_valid, y_in, x_in, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, y_in, x_in, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/atan_vectoring.sv
// Iterative vectoring CORDIC: float (y, x) -> float atan angle.
// Define ATAN_QUADRANT_EN for full atan2; otherwise atan(y/|x|).
module atan_vectoring #(
    parameter int WIDTH      = 24,
    parameter int ITERATIONS = 24
) (
    input logic             clk,
    input logic             reset,
    input logic             clk_en,
    atan_vectoring_if.slave bus
);

    localparam int W   = WIDTH + 3;
    localparam int IW  = $clog2(ITERATIONS + 1);
    localparam int LSH = (WIDTH > 24) ? WIDTH - 24 : 0;
    localparam int RSH = (WIDTH < 24) ? 24 - WIDTH : 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    state_t                state;
    logic [31:0]           y_raw;
    logic [31:0]           x_raw;
    logic signed [W-1:0]   x;
    logic signed [W-1:0]   y;
    logic signed [W-1:0]   z;
    logic [IW-1:0]         i;
    logic [31:0]           result_q;
    logic                  out_valid_q;

    logic signed [W-1:0]   ux;
    logic signed [W-1:0]   uy;
    logic signed [W-1:0]   xs;
    logic signed [W-1:0]   ys;
    logic signed [W-1:0]   at;
    logic signed [W-1:0]   xn;
    logic signed [W-1:0]   yn;
    logic signed [W-1:0]   zn;

`ifdef ATAN_QUADRANT_EN
    localparam logic signed [W-1:0] HALF_PI =
        W'((64'd26353589 << LSH) >> RSH);
`endif

    // atan(2^-idx) in Q2.24, rescaled to WIDTH fractional bits
    function automatic logic signed [W-1:0] atan_lut(
        input int idx
    );
        logic [63:0] q;
        case (idx)
            0:       q = 64'd13176795;
            1:       q = 64'd7778716;
            2:       q = 64'd4110060;
            3:       q = 64'd2086331;
            4:       q = 64'd1047214;
            5:       q = 64'd524117;
            6:       q = 64'd262123;
            7:       q = 64'd131069;
            8:       q = 64'd65536;
            default: begin
                if (idx >= 9 && idx <= 24)
                    q = 64'd1 << (24 - idx);
                else
                    q = 64'd0;
            end
        endcase
        return W'((q << LSH) >> RSH);
    endfunction

    function automatic logic signed [W-1:0] unpack(
        input logic [31:0] f
    );
        logic [W+23:0]       m;
        logic signed [W-1:0] v;
        int                  sh;
        if (f[30:23] == 8'd0)
            return '0;
        sh = 150 - int'(f[30:23]);
        if (sh < 0)
            sh = 0;
        m = {{W{1'b0}}, 1'b1, f[22:0]} << WIDTH;
        v = W'(m >> sh);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] pack(
        input logic signed [W-1:0] v
    );
        logic [W-1:0] m;
        int           p;
        m = v[W-1] ? W'(-v) : W'(v);
        p = -1;
        for (int k = 0; k < W; k++)
            if (m[k])
                p = k;
        if (p < 0)
            return 32'd0;
        return {v[W-1], 8'(p - WIDTH + 127),
                23'({m, 23'd0} >> p)};
    endfunction

    assign bus.in_ready  = (state == IDLE) && !reset && clk_en;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    always_comb begin
        uy = unpack(y_raw);
`ifdef ATAN_QUADRANT_EN
        ux = unpack(x_raw);
`else
        ux = unpack(x_raw & 32'h7FFF_FFFF);
`endif
    end

    // Shared micro-rotation; y == 0 rotates as if positive
    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        at = atan_lut(int'(i));
        if (y[W-1]) begin
            xn = x - ys;
            yn = y + xs;
            zn = z - at;
        end else begin
            xn = x + ys;
            yn = y - xs;
            zn = z + at;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            y_raw       <= '0;
            x_raw       <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            i           <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (clk_en) begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        y_raw <= bus.y_in;
                        x_raw <= bus.x_in;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    i     <= '0;
                    state <= ITER;
`ifdef ATAN_QUADRANT_EN
                    if (ux[W-1] && !uy[W-1]) begin
                        x <= uy;
                        y <= -ux;
                        z <= HALF_PI;
                    end else if (ux[W-1]) begin
                        x <= -uy;
                        y <= ux;
                        z <= -HALF_PI;
                    end else begin
                        x <= ux;
                        y <= uy;
                        z <= '0;
                    end
`else
                    x <= ux;
                    y <= uy;
                    z <= '0;
`endif
                end
                ITER: begin
                    x <= xn;
                    y <= yn;
                    z <= zn;
                    i <= i + 1'b1;
                    if (i == IW'(ITERATIONS - 1)) begin
                        result_q    <= pack(zn);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atan_vectoring.sv
// Scoreboard bench for atan_vectoring: random and directed operand
// pairs checked against a real-valued atan2 reference.
module tb_atan_vectoring;

    localparam real TOL = 4.0e-6;
    localparam real ONE = 16777216.0;

    typedef struct {
        real   exp;
        int    lat;
        int    hs;
        string name;
    } item_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  clk_en;
    int    cyc = 0;
    int    checks = 0;
    int    passed = 0;
    item_t sb[$];

    atan_vectoring_if bus ();

    atan_vectoring #(
        .WIDTH(24),
        .ITERATIONS(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok,
                         input string got, input string want);
        checks++;
        if (ok)
            passed++;
        else
            $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0)
            return 0.0;
        m = 1.0 + real'(int'(b[22:0])) / 8388608.0;
        while (e > 127) begin m = m * 2.0; e--; end
        while (e < 127) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    // k/2^24 as a single-precision pattern (exact for k <= 2^24)
    function automatic logic [31:0] mkf(input bit neg, input int k);
        logic [63:0] kk;
        int          p;
        if (k == 0)
            return 32'd0;
        kk = 64'(k);
        p  = 0;
        for (int j = 0; j <= 24; j++)
            if (kk[j])
                p = j;
        return {neg, 8'(127 + p - 24), 23'((kk << 23) >> p)};
    endfunction

    function automatic real ref_angle(input real yr, input real xr);
`ifdef ATAN_QUADRANT_EN
        return $atan2(yr, xr);
`else
        return $atan2(yr, (xr < 0.0) ? -xr : xr);
`endif
    endfunction

    task automatic send(input logic [31:0] yb, input logic [31:0] xb,
                        input real ex, input int lat,
                        input string name, output int hs);
        int    n;
        item_t it;
        n = 0;
        hs = -1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.y_in     = yb;
        bus.x_in     = xb;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            check({name, "_accept"}, 1'b0, "in_ready low", "in_ready high");
            bus.in_valid = 1'b0;
            return;
        end
        it.exp  = ex;
        it.lat  = lat;
        it.hs   = cyc;
        it.name = name;
        hs      = cyc;
        sb.push_back(it);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_op(input bit yneg, input int yk,
                         input bit xneg, input int xk,
                         input int lat, input string name);
        real yr;
        real xr;
        int  hs;
        yr = real'(yk) / ONE;
        xr = real'(xk) / ONE;
        if (yneg) yr = -yr;
        if (xneg) xr = -xr;
        send(mkf(yneg, yk), mkf(xneg, xk), ref_angle(yr, xr),
             lat, name, hs);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, sb.size() == 0,
              $sformatf("%0d pending", sb.size()), "0 pending");
        @(negedge clk);
    endtask

    task automatic quiet(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            #2;
            if (bus.out_valid)
                seen = 1'b1;
        end
        check(name, !seen, $sformatf("out_valid=%0b", seen), "out_valid=0");
    endtask

    // Monitor: pops the oldest expectation on every output transfer
    initial begin
        item_t it;
        real   r;
        real   d;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1'b0,
                          $sformatf("result %h", bus.result), "no output");
                end else begin
                    it = sb.pop_front();
                    r  = f2r(bus.result);
                    d  = r - it.exp;
                    if (d < 0.0) d = -d;
                    check({it.name, "_val"}, d <= TOL,
                          $sformatf("%h (%.7f)", bus.result, r),
                          $sformatf("%.7f", it.exp));
                    if (it.lat >= 0)
                        check({it.name, "_lat"}, cyc - it.hs == it.lat,
                              $sformatf("%0d", cyc - it.hs),
                              $sformatf("%0d", it.lat));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          hs1;
        int          hs2;
        int          lat;
        int          major;
        int          minor;
        bit          swap;
        logic [31:0] r0;
        item_t       dropped;

        reset         = 1'b1;
        clk_en        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.y_in      = '0;
        bus.x_in      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready == 1'b0,
              $sformatf("%0b", bus.in_ready), "0");
        check("rst_out_valid", bus.out_valid == 1'b0,
              $sformatf("%0b", bus.out_valid), "0");
        check("rst_result", bus.result == 32'd0,
              $sformatf("%h", bus.result), "00000000");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_in_ready", bus.in_ready == 1'b1,
              $sformatf("%0b", bus.in_ready), "1");

        send(32'h3F800000, 32'h3F800000, f2r(32'h3F490FDB),
             26, "pi_4", hs1);
        send(32'h3F000000, 32'h3F800000, f2r(32'h3EED6338),
             26, "half", hs2);
        check("throughput", hs2 - hs1 == 27,
              $sformatf("%0d", hs2 - hs1), "27");
        send(32'hBF800000, 32'h3F800000, f2r(32'hBF490FDB),
             26, "neg_pi_4", hs1);
`ifdef ATAN_QUADRANT_EN
        send(32'h3F800000, 32'hBF800000, f2r(32'h4016CBE4),
             26, "q135", hs1);
`else
        send(32'h3F800000, 32'hBF800000, f2r(32'h3F490FDB),
             26, "q135", hs1);
`endif
        do_op(0, 0, 0, 1 << 24, 26, "y_zero");
        do_op(0, 1 << 24, 0, 0, 26, "x_zero");
        do_op(1, 1 << 24, 0, 0, 26, "x_zero_neg");
        do_op(0, 0, 1, 1 << 24, 26, "neg_x_axis");
        do_op(1, 1 << 24, 1, 1 << 23, 26, "q3");
        do_op(0, 1, 0, 1 << 24, 26, "tiny_y");
        wait_idle("directed");

        for (int n = 0; n < 30; n++) begin
            major = int'($urandom_range(1 << 24, 1 << 23));
            minor = int'($urandom_range(1 << 24, 0));
            swap  = 1'($urandom);
            if (swap)
                do_op(1'($urandom), minor, 1'($urandom), major,
                      26, $sformatf("rnd%0d", n));
            else
                do_op(1'($urandom), major, 1'($urandom), minor,
                      26, $sformatf("rnd%0d", n));
            repeat (int'($urandom_range(2, 0))) @(negedge clk);
        end
        wait_idle("random");

        bus.out_ready = 1'b0;
        do_op(0, 3 << 22, 0, 1 << 23, -1, "bp");
        lat = 0;
        do begin
            @(negedge clk);
            #2;
            lat++;
        end while (!bus.out_valid && lat < 100);
        check("bp_lat", lat == 26, $sformatf("%0d", lat), "26");
        r0 = bus.result;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = k[0];
            bus.y_in     = 32'h3F000000;
            bus.x_in     = 32'h3F000000;
            #2;
            check($sformatf("bp_hold%0d", k),
                  bus.out_valid && !bus.in_ready && bus.result == r0,
                  $sformatf("v=%0b r=%0b res=%h", bus.out_valid,
                            bus.in_ready, bus.result),
                  $sformatf("v=1 r=0 res=%h", r0));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_ready", bus.in_ready == 1'b1,
              $sformatf("%0b", bus.in_ready), "1");
        quiet("bp_no_extra", 40);

        do_op(0, 1 << 22, 0, 1 << 24, 26, "abort");
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_in_ready", bus.in_ready == 1'b0,
              $sformatf("%0b", bus.in_ready), "0");
        @(negedge clk);
        reset = 1'b0;
        dropped = sb.pop_back();
        #1;
        check("abort_cleared",
              !bus.out_valid && bus.result == 32'd0 && bus.in_ready,
              $sformatf("v=%0b res=%h r=%0b", bus.out_valid,
                        bus.result, bus.in_ready),
              "v=0 res=00000000 r=1");
        quiet({dropped.name, "_no_out"}, 40);
        do_op(1, 1 << 23, 0, 3 << 22, 26, "after_abort");
        wait_idle("after_abort");

        do_op(0, 1 << 24, 1, 1 << 23, 33, "clken");
        repeat (3) @(negedge clk);
        clk_en = 1'b0;
        repeat (7) @(negedge clk);
        clk_en = 1'b1;
        wait_idle("clken");

        @(negedge clk);
        clk_en       = 1'b0;
        bus.in_valid = 1'b1;
        bus.y_in     = 32'h3F800000;
        bus.x_in     = 32'h3F800000;
        #1;
        check("clken_mask_ready", bus.in_ready == 1'b0,
              $sformatf("%0b", bus.in_ready), "0");
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        clk_en       = 1'b1;
        #1;
        check("clken_ready_back", bus.in_ready == 1'b1,
              $sformatf("%0b", bus.in_ready), "1");
        quiet("clken_no_accept", 40);

        wait_idle("final");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
